// File: rtl/lsu_pkg.sv
// Shared definitions for the lsu_mem data-memory unit: op encoding, FSM states
// and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_D  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam logic [2:0] OP_WU = 3'b110;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} lsu_state_e;

    // Op legality independent of address: width support and no unsigned stores.
    function automatic logic op_legal(input logic [2:0] op, input logic wen,
                                      input int unsigned xlen);
        logic ok;
        case (op)
            OP_B, OP_H, OP_W: ok = 1'b1;
            OP_D:             ok = (xlen == 64);
            OP_BU, OP_HU:     ok = !wen;
            OP_WU:            ok = (xlen == 64) && !wen;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Access size in bytes, encoded in the low two op bits.
    function automatic logic [3:0] op_bytes(input logic [2:0] op);
        logic [3:0] n;
        case (op[1:0])
            2'd0:    n = 4'd1;
            2'd1:    n = 4'd2;
            2'd2:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for lsu_mem: store strobe/data placement and load
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [2:0]                op_i,
    input  logic [XLEN-1:0]           wdata_i,
    input  logic [XLEN-1:0]           rword_i,
    output logic [XLEN/8-1:0]         strb_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic [XLEN-1:0]           rdata_o
);

    logic [XLEN/8-1:0] mask;
    logic [XLEN-1:0]   shifted;

    // Lane mask by size, then move both mask and data up to the addressed lane.
    always_comb begin
        mask = '0;
        case (op_i[1:0])
            2'd0:    mask[0]   = 1'b1;
            2'd1:    mask[1:0] = '1;
            2'd2:    mask[3:0] = '1;
            default: mask      = '1;
        endcase
        strb_o  = mask << off_i;
        wdata_o = wdata_i << {off_i, 3'b000};
    end

    // Bring the addressed lanes down to bit 0 and extend to XLEN.
    always_comb begin
        shifted = rword_i >> {off_i, 3'b000};
        case (op_i)
            OP_B:         rdata_o = XLEN'($signed(shifted[7:0]));
            OP_H:         rdata_o = XLEN'($signed(shifted[15:0]));
            OP_W:         rdata_o = XLEN'($signed(shifted[31:0]));
            OP_BU:        rdata_o = XLEN'(shifted[7:0]);
            OP_HU:        rdata_o = XLEN'(shifted[15:0]);
            OP_WU:        rdata_o = XLEN'(shifted[31:0]);
            default:      rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Multi-cycle data-memory unit with valid/ready request/response handshake,
// one access in flight, backed by an internal byte-laned array.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [31:0]     req_addr_i,
    input  logic            req_wen_i,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int unsigned NB       = XLEN / 8;
    localparam int unsigned OffW     = $clog2(NB);
    localparam logic [32:0] MemBytes = 33'(DEPTH) * 33'(NB);

    lsu_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     addr_q;
    logic            wen_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;
    logic [XLEN-1:0] raw_q;

    logic [31:0]     rel_addr;
    logic [3:0]      nbytes;
    logic            req_ok;
    logic            accept;
    logic            access;
    logic [NB-1:0]   strb;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] ld_val;

    // Legality of the incoming request: op, natural alignment and range.
    always_comb begin
        rel_addr = req_addr_i - BASE_ADDR;
        nbytes   = op_bytes(req_op_i);
        req_ok   = op_legal(req_op_i, req_wen_i, XLEN)
                && ((req_addr_i & (32'(nbytes) - 32'd1)) == 32'd0)
                && (req_addr_i >= BASE_ADDR)
                && ((33'(rel_addr) + 33'(nbytes)) <= MemBytes);
    end

    assign accept = req_valid_i && (state_q == StIdle);
    assign access = (state_q == StBusy) && (cnt_q == 4'd0);

    // Next-state logic: faults skip BUSY and respond immediately.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (req_ok) begin
                        state_d = StBusy;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and latency counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; err is decided at accept and held through RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            op_q    <= OP_B;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr_i;
            wen_q   <= req_wen_i;
            op_q    <= req_op_i;
            wdata_q <= req_wdata_i;
            err_q   <= !req_ok;
        end
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .off_i   (addr_q[OffW-1:0]),
        .op_i    (op_q),
        .wdata_i (wdata_q),
        .rword_i (raw_q),
        .strb_o  (strb),
        .wdata_o (wdata_sh),
        .rdata_o (ld_val)
    );

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [31:0]     word_off;
    logic [IdxW-1:0] idx;

    assign word_off = (addr_q - BASE_ADDR) >> OffW;
    assign idx      = IdxW'(word_off);

    // Single array access at the end of BUSY; reset on that edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_q <= '0;
        end else if (access) begin
            raw_q <= mem[idx];
            if (wen_q) begin
                for (int i = 0; i < NB; i++) begin
                    if (strb[i]) begin
                        mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                    end
                end
            end
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_err_o   = err_q;
    // Stores and faults return zero; loads are extended from the held raw word.
    assign rsp_rdata_o = (err_q || wen_q) ? '0 : ld_val;

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem (XLEN=32, LATENCY=3, 256-byte memory).
module tb_lsu_mem;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned LATENCY   = 3;
    localparam int unsigned DEPTH     = 64;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          MEM_BYTES = DEPTH * XLEN / 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] mm [MEM_BYTES];

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [2:0]  op;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl [20];

    lsu_mem #(
        .XLEN      (XLEN),
        .LATENCY   (LATENCY),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_wen_i   (req_wen),
        .req_op_i    (req_op),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte-array reference: legality from the access rules, little-endian assembly.
    function automatic void model(input logic [31:0] a, input logic w, input logic [2:0] op,
                                  input logic [31:0] d, output logic [31:0] rd,
                                  output logic er);
        int     size;
        longint off;
        logic [31:0] v;
        size = 1 << op[1:0];
        off  = longint'(a) - longint'(BASE);
        er   = (op == 3'd7) || (op == 3'd3) || (op == 3'd6) || (w && op[2])
            || ((a % size) != 0) || (off < 0) || (off + size > MEM_BYTES);
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) mm[int'(off) + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mm[int'(off) + i]) << (8*i));
                if (!op[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
            end
        end
    endfunction

    // One transaction with rsp_ready high. lat = clock edges after the accepting
    // edge until rsp_valid is visible. Called and returns at a negedge.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [2:0] op,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_ready_wait: got 0, expected 1 within 50 cycles");
        end
        req_addr  = a;
        req_wen   = w;
        req_op    = op;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        logic [2:0]  op;
        logic        w;
        logic [31:0] a, d;
        int          r;

        tbl[0]  = '{32'h8000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{32'h8000_0010, 1'b0, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{32'h8000_0013, 1'b0, 3'b000, 32'h0,         32'hFFFF_FFDE, 1'b0};
        tbl[3]  = '{32'h8000_0013, 1'b0, 3'b100, 32'h0,         32'h0000_00DE, 1'b0};
        tbl[4]  = '{32'h8000_0010, 1'b0, 3'b101, 32'h0,         32'h0000_BEEF, 1'b0};
        tbl[5]  = '{32'h8000_0011, 1'b1, 3'b000, 32'h0000_0012, 32'h0000_0000, 1'b0};
        tbl[6]  = '{32'h8000_0010, 1'b0, 3'b010, 32'h0,         32'hDEAD_12EF, 1'b0};
        tbl[7]  = '{32'h8000_0002, 1'b0, 3'b010, 32'h0,         32'h0000_0000, 1'b1};
        tbl[8]  = '{32'h7FFF_FFFC, 1'b0, 3'b010, 32'h0,         32'h0000_0000, 1'b1};
        tbl[9]  = '{32'h8000_0010, 1'b0, 3'b011, 32'h0,         32'h0000_0000, 1'b1};
        tbl[10] = '{32'h8000_0010, 1'b0, 3'b010, 32'h0,         32'hDEAD_12EF, 1'b0};
        tbl[11] = '{32'h8000_0012, 1'b0, 3'b001, 32'h0,         32'hFFFF_DEAD, 1'b0};
        tbl[12] = '{32'h8000_0100, 1'b1, 3'b010, 32'h1111_1111, 32'h0000_0000, 1'b1};
        tbl[13] = '{32'h8000_0010, 1'b1, 3'b100, 32'h0000_0077, 32'h0000_0000, 1'b1};
        tbl[14] = '{32'h8000_0010, 1'b0, 3'b111, 32'h0,         32'h0000_0000, 1'b1};
        tbl[15] = '{32'h8000_00FE, 1'b1, 3'b001, 32'h0000_A5A5, 32'h0000_0000, 1'b0};
        tbl[16] = '{32'h8000_00FC, 1'b0, 3'b010, 32'h0,         32'hA5A5_0000, 1'b0};
        tbl[17] = '{32'h8000_0011, 1'b0, 3'b001, 32'h0,         32'h0000_0000, 1'b1};
        tbl[18] = '{32'h8000_0010, 1'b0, 3'b010, 32'h0,         32'hDEAD_12EF, 1'b0};
        tbl[19] = '{32'h8000_0010, 1'b0, 3'b110, 32'h0,         32'h0000_0000, 1'b1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_op    = 3'b0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);

        // Memory is not cleared by reset: give every word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            do_req(BASE + 32'(4 * i), 1'b1, 3'b010, 32'd0, rd, er, lat);
            model(BASE + 32'(4 * i), 1'b1, 3'b010, 32'd0, mrd, mer);
        end

        for (int i = 0; i < 20; i++) begin
            do_req(tbl[i].addr, tbl[i].wen, tbl[i].op, tbl[i].wdata, rd, er, lat);
            model(tbl[i].addr, tbl[i].wen, tbl[i].op, tbl[i].wdata, mrd, mer);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].err));
            // Faults respond in the cycle after accept; legal accesses LATENCY edges later.
            check($sformatf("tbl%0d_latency", i), 32'(lat),
                  tbl[i].err ? 32'd0 : 32'(LATENCY));
        end

        // Back-pressure: response held stable for 5 cycles with rsp_ready low.
        rsp_ready = 1'b0;
        req_addr  = 32'h8000_0010;
        req_wen   = 1'b0;
        req_op    = 3'b010;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_rdata", k), rsp_rdata, 32'hDEAD_12EF);
            check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_req_ready", 32'(req_ready), 32'd1);

        // Reset lands on the very edge where the store would be performed.
        req_addr  = 32'h8000_0020;
        req_wen   = 1'b1;
        req_op    = 3'b010;
        req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_busy%0d_rsp_valid", k), 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("rst_busy_req_ready", 32'(req_ready), 32'd1);
        do_req(32'h8000_0020, 1'b0, 3'b010, 32'd0, rd, er, lat);
        check("rst_busy_no_write", rd, 32'd0);
        check("rst_busy_load_err", 32'(er), 32'd0);

        // Randomized traffic against the byte-array model.
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 1) a = BASE + 32'(MEM_BYTES) + 32'($urandom_range(0, 15));
            else a = BASE + 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << op[1:0]) - 32'd1);
            do_req(a, w, op, d, rd, er, lat);
            model(a, w, op, d, mrd, mer);
            check($sformatf("rnd%0d_rdata", n), rd, mrd);
            check($sformatf("rnd%0d_err", n), 32'(er), 32'(mer));
            check($sformatf("rnd%0d_latency", n), 32'(lat), mer ? 32'd0 : 32'(LATENCY));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
